// File: rtl/obi_uart_rx_frame_if.sv
// rtl/obi_uart_rx_frame_if.sv - RX FIFO read-side bundle between framer and register file
interface obi_uart_rx_frame_if;
    logic       pop_i;
    logic       ovr_clr_i;
    logic [7:0] rx_data_o;
    logic       rx_par_err_o;
    logic       rx_frame_err_o;
    logic       rx_break_o;
    logic       rx_valid_o;
    logic [4:0] rx_usage_o;
    logic       overrun_o;
    logic       fifo_err_o;

    modport master (
        output pop_i, ovr_clr_i,
        input  rx_data_o, rx_par_err_o, rx_frame_err_o, rx_break_o,
        input  rx_valid_o, rx_usage_o, overrun_o, fifo_err_o
    );

    modport slave (
        input  pop_i, ovr_clr_i,
        output rx_data_o, rx_par_err_o, rx_frame_err_o, rx_break_o,
        output rx_valid_o, rx_usage_o, overrun_o, fifo_err_o
    );
endinterface

// File: rtl/obi_uart_rx_frame.sv
// rtl/obi_uart_rx_frame.sv - UART receive framer with 16x oversampling and RX FIFO
module obi_uart_rx_frame #(
    parameter int DEPTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 oversample_edge_i,
    input  logic                 rxd_i,
    input  logic [1:0]           word_len_i,
    input  logic                 par_en_i,
    input  logic [1:0]           par_sel_i,
    input  logic                 fifo_en_i,
    input  logic                 fifo_rst_i,
    obi_uart_rx_frame_if.slave   rx_if
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

    state_e        state_q, state_d;
    logic          rxd_meta_q, rxs_q;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    wl_q, wl_d, psel_q, psel_d;
    logic          pen_q, pen_d, par_err_q, par_err_d, par_bit_q, par_bit_d;
    logic          par_exp, brk, push;
    logic [10:0]   push_entry;

    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [4:0]    usage_q, usage_d, err_cnt_q, err_cnt_d, cap;
    logic          overrun_q, overrun_d, fifo_en_q;
    logic          clr, full, do_push, do_pop;
    logic [10:0]   head;

    always_comb begin
        unique case (psel_q)
            2'b00:   par_exp = ~^shift_q;
            2'b01:   par_exp = ^shift_q;
            2'b10:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    // Break: every bit of the character, including parity when present and the stop bit, is low.
    assign brk        = (shift_q == 8'd0) && (!pen_q || !par_bit_q) && !rxs_q;
    assign push_entry = {shift_q, par_err_q, ~rxs_q, brk};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        wl_d      = wl_q;
        pen_d     = pen_q;
        psel_d    = psel_q;
        par_err_d = par_err_q;
        par_bit_d = par_bit_q;
        push      = 1'b0;
        if (oversample_edge_i) begin
            cnt_d = cnt_q + 4'd1;
            unique case (state_q)
                IDLE: begin
                    cnt_d = 4'd0;
                    if (!rxs_q) state_d = START;
                end
                START: if (cnt_q == 4'd7) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        wl_d      = word_len_i;
                        pen_d     = par_en_i;
                        psel_d    = par_sel_i;
                        cnt_d     = 4'd0;
                        idx_d     = 3'd0;
                        shift_d   = 8'd0;
                        par_err_d = 1'b0;
                        par_bit_d = 1'b0;
                        state_d   = DATA;
                    end
                end
                DATA: if (cnt_q == 4'd15) begin
                    shift_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                    // Last data bit index is 4 + word length code.
                    if (idx_q == {1'b1, wl_q}) state_d = pen_q ? PAR : STOP;
                end
                PAR: if (cnt_q == 4'd15) begin
                    par_bit_d = rxs_q;
                    par_err_d = (rxs_q != par_exp);
                    state_d   = STOP;
                end
                STOP: if (cnt_q == 4'd15) begin
                    push    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign head = mem_q[rptr_q];

    always_comb begin
        clr       = fifo_rst_i || (fifo_en_i != fifo_en_q);
        cap       = fifo_en_i ? 5'(DEPTH) : 5'd1;
        full      = (usage_q >= cap);
        do_pop    = rx_if.pop_i && (usage_q != 5'd0) && !clr;
        do_push   = push && (!full || do_pop) && !clr;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        usage_d   = usage_q;
        err_cnt_d = err_cnt_q;
        overrun_d = overrun_q;
        if (rx_if.ovr_clr_i) overrun_d = 1'b0;
        if (push && !clr && !do_push) overrun_d = 1'b1;
        if (clr) begin
            rptr_d    = '0;
            wptr_d    = '0;
            usage_d   = 5'd0;
            err_cnt_d = 5'd0;
        end else begin
            if (do_push) begin
                wptr_d = (fifo_en_i) ? wptr_q + 1'b1 : '0;
                if (|push_entry[2:0]) err_cnt_d = err_cnt_d + 5'd1;
            end
            if (do_pop) begin
                rptr_d = (fifo_en_i) ? rptr_q + 1'b1 : '0;
                if (|head[2:0]) err_cnt_d = err_cnt_d - 5'd1;
            end
            if (do_push && !do_pop) usage_d = usage_q + 5'd1;
            if (do_pop && !do_push) usage_d = usage_q - 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= 3'd0;
            shift_q    <= 8'd0;
            wl_q       <= 2'd0;
            pen_q      <= 1'b0;
            psel_q     <= 2'd0;
            par_err_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            usage_q    <= 5'd0;
            err_cnt_q  <= 5'd0;
            overrun_q  <= 1'b0;
            fifo_en_q  <= fifo_en_i;
        end else begin
            rxd_meta_q <= rxd_i;
            rxs_q      <= rxd_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            wl_q       <= wl_d;
            pen_q      <= pen_d;
            psel_q     <= psel_d;
            par_err_q  <= par_err_d;
            par_bit_q  <= par_bit_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            usage_q    <= usage_d;
            err_cnt_q  <= err_cnt_d;
            overrun_q  <= overrun_d;
            fifo_en_q  <= fifo_en_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_entry;
    end

    assign rx_if.rx_valid_o     = (usage_q != 5'd0);
    assign rx_if.rx_data_o      = rx_if.rx_valid_o ? head[10:3] : 8'd0;
    assign rx_if.rx_par_err_o   = rx_if.rx_valid_o & head[2];
    assign rx_if.rx_frame_err_o = rx_if.rx_valid_o & head[1];
    assign rx_if.rx_break_o     = rx_if.rx_valid_o & head[0];
    assign rx_if.rx_usage_o     = usage_q;
    assign rx_if.overrun_o      = overrun_q;
    assign rx_if.fifo_err_o     = (err_cnt_q != 5'd0);
endmodule
